// File: rtl/commit_trace_buffer_if.sv
// Commit trace bus: the commit-event input and the drained-trace output handshake.
interface commit_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int INUM_W = 16
);
  localparam int ENTRY_W = 6 + INUM_W + 3 * DATA_W;

  logic               ev_valid;
  logic [1:0]         ev_kind;
  logic [DATA_W-1:0]  ev_pc;
  logic [3:0]         ev_reg;
  logic [DATA_W-1:0]  ev_data;
  logic [DATA_W-1:0]  ev_addr;

  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_data;

  // The trace unit sees events as inputs and drives the drain side.
  modport slave (
    input  ev_valid, ev_kind, ev_pc, ev_reg, ev_data, ev_addr, out_ready,
    output out_valid, out_data
  );

  // The commit stage / consumer drive events and accept drained entries.
  modport master (
    output ev_valid, ev_kind, ev_pc, ev_reg, ev_data, ev_addr, out_ready,
    input  out_valid, out_data
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: records accepted commit events into a show-ahead
// FIFO, counts instructions, cycles and overflow drops, and stops capturing
// after a halt event or a watchdog timeout.
module commit_trace_buffer #(
  parameter int DATA_W      = 16,
  parameter int INUM_W      = 16,
  parameter int DEPTH       = 8,
  parameter int CYCLE_LIMIT = 100000,
  localparam int ENTRY_W    = 6 + INUM_W + 3 * DATA_W,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [3:0]          kind_en,
  commit_trace_buffer_if.slave trace,
  output logic [CNT_W-1:0]    count,
  output logic [INUM_W-1:0]   inst_cnt,
  output logic [31:0]         cycle_cnt,
  output logic [15:0]         drop_cnt,
  output logic                halted,
  output logic                timeout,
  output logic                done
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      LIMIT_C = 32'(CYCLE_LIMIT);
  localparam logic [1:0]       KIND_HALT = 2'b11;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INUM_W-1:0]  inst_cnt_q, inst_cnt_d;
  logic [31:0]        cycle_cnt_q, cycle_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;

  logic               accept;
  logic               halt_acc;
  logic               pop;
  logic               push;
  logic               running;
  logic [ENTRY_W-1:0] entry;

  // Accept/push/pop decisions for this cycle, based only on registered state.
  always_comb begin
    running  = ~halted_q & ~timeout_q;
    accept   = trace.ev_valid & kind_en[trace.ev_kind] & running;
    halt_acc = accept & (trace.ev_kind == KIND_HALT);
    pop      = (count_q != '0) & trace.out_ready;
    push     = accept & ((count_q < DEPTH_C) | pop);
    entry    = {trace.ev_kind, trace.ev_reg, inst_cnt_q,
                trace.ev_pc, trace.ev_data, trace.ev_addr};
  end

  // Next-state for the FIFO, counters and sticky flags; reset/clear wins.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    inst_cnt_d  = inst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;

    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (accept) begin
      inst_cnt_d = inst_cnt_q + 1'b1;
      if (!push && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    if (running) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (cycle_cnt_d == LIMIT_C && !halt_acc) begin
        timeout_d = 1'b1;
      end
    end

    if (halt_acc) begin
      halted_d = 1'b1;
    end

    if (!rst_n || clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      inst_cnt_d  = '0;
      cycle_cnt_d = '0;
      drop_cnt_d  = '0;
      halted_d    = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  // State registers; the storage array needs no reset since count gates it.
  always_ff @(posedge clk) begin
    mem_q       <= mem_d;
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    inst_cnt_q  <= inst_cnt_d;
    cycle_cnt_q <= cycle_cnt_d;
    drop_cnt_q  <= drop_cnt_d;
    halted_q    <= halted_d;
    timeout_q   <= timeout_d;
  end

  // Show-ahead head entry, forced to zero when empty so reset reads as zero.
  always_comb begin
    trace.out_valid = (count_q != '0);
    trace.out_data  = trace.out_valid ? mem_q[rd_ptr_q] : '0;
    count           = count_q;
    inst_cnt        = inst_cnt_q;
    cycle_cnt       = cycle_cnt_q;
    drop_cnt        = drop_cnt_q;
    halted          = halted_q;
    timeout         = timeout_q;
    done            = halted_q & (count_q == '0);
  end

endmodule
